// File: rtl/assoc_wb_cache_pkg.sv
// cache_pkg: shared FSM state type and tag-width helper for the set-associative cache
package cache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  function automatic int tag_w(input int addr_width, input int sets);
    return addr_width - 2 - $clog2(sets);
  endfunction
endpackage

// File: rtl/assoc_wb_cache_if.sv
// assoc_wb_cache_if: CPU request/response and memory req/ack signals of the cache
interface assoc_wb_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  hit;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    output req, we, addr, wdata, mem_ack, mem_rdata,
    input  ready, rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  req, we, addr, wdata, mem_ack, mem_rdata,
    output ready, rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_wb_cache_lru_tracker.sv
// lru_tracker: per-set true-LRU age registers and victim selection
module lru_tracker #(
  parameter  int SETS  = 4,
  parameter  int WAYS  = 2,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_upd,
  input  logic [SET_W-1:0] i_set,
  input  logic [WAY_W-1:0] i_way,
  input  logic [SET_W-1:0] i_qset,
  input  logic [WAYS-1:0]  i_valid,
  output logic [WAY_W-1:0] o_victim
);
  if (WAYS > 1) begin : g_lru
    localparam int AGE_W = $clog2(WAYS);
    logic [AGE_W-1:0] r_age [SETS][WAYS];
    // accessed way becomes youngest, ways younger than it age by one
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            r_age[s][w] <= AGE_W'(w);
      end else if (i_upd) begin
        for (int w = 0; w < WAYS; w++)
          r_age[i_set][w] <= (w == int'(i_way)) ? '0 :
                             (r_age[i_set][w] < r_age[i_set][i_way]) ? r_age[i_set][w] + 1'b1 :
                             r_age[i_set][w];
      end
    end
    // lowest invalid way wins, otherwise the oldest way
    always_comb begin
      o_victim = '0;
      for (int w = WAYS - 1; w >= 0; w--)
        if ((&i_valid) ? (r_age[i_qset][w] == AGE_W'(WAYS - 1)) : !i_valid[w])
          o_victim = WAY_W'(w);
    end
  end else begin : g_dm
    assign o_victim = '0;
  end
endmodule

// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: N-way set-associative write-back write-allocate cache with true LRU
module assoc_wb_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 4,
  parameter int WAYS       = 2
) (
  input logic             clk,
  input logic             rst,
  assoc_wb_cache_if.slave bus
);
  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = tag_w(ADDR_WIDTH, SETS);
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] data;
  } line_t;
  line_t            r_lines [SETS][WAYS];
  state_t           r_state, w_next;
  logic [WAY_W-1:0] r_victim, w_victim, w_hit_way;
  logic [WAYS-1:0]  w_match, w_valid;
  logic             w_hit, w_idle_hit, w_miss;
  logic [SET_W-1:0] w_set;
  logic [TAG_W-1:0] w_tag;
  logic             w_unused;
  assign w_set      = bus.addr[2+SET_W-1:2];
  assign w_tag      = bus.addr[ADDR_WIDTH-1:2+SET_W];
  assign w_unused   = &{1'b0, bus.addr[1:0]};
  assign w_idle_hit = r_state == IDLE && w_hit;
  assign w_miss     = r_state == IDLE && bus.req && !w_hit;
  // combinational tag lookup across all ways of the addressed set
  always_comb begin
    w_match   = '0;
    w_valid   = '0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_valid[w] = r_lines[w_set][w].valid;
      w_match[w] = w_valid[w] && r_lines[w_set][w].tag == w_tag;
      if (w_match[w]) w_hit_way = WAY_W'(w);
    end
    w_hit = bus.req && |w_match;
  end
  lru_tracker #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk      (clk),
    .rst      (rst),
    .i_upd    (w_idle_hit),
    .i_set    (w_set),
    .i_way    (w_hit_way),
    .i_qset   (w_set),
    .i_valid  (w_valid),
    .o_victim (w_victim)
  );
  // victim is frozen at the start of a miss so write-back and refill target one way
  always_ff @(posedge clk) begin
    if (rst) r_victim <= '0;
    else if (w_miss) r_victim <= w_victim;
  end
  // miss FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // miss FSM next state: dirty victims are written back before the refill
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_miss ? ((r_lines[w_set][w_victim].valid && r_lines[w_set][w_victim].dirty) ? WRITEBACK : REFILL) : IDLE;
      WRITEBACK: w_next = bus.mem_ack ? REFILL : WRITEBACK;
      REFILL:    w_next = bus.mem_ack ? IDLE : REFILL;
      default:   w_next = IDLE;
    endcase
  end
  // CPU and memory outputs decoded from state and the addressed lines
  always_comb begin
    bus.ready     = w_idle_hit;
    bus.hit       = w_hit;
    bus.rdata     = (w_idle_hit && !bus.we) ? r_lines[w_set][w_hit_way].data : '0;
    bus.mem_req   = r_state != IDLE;
    bus.mem_we    = r_state == WRITEBACK;
    bus.mem_addr  = (r_state == WRITEBACK) ? {r_lines[w_set][r_victim].tag, w_set, 2'b00} :
                    (r_state == REFILL) ? {bus.addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    bus.mem_wdata = (r_state == WRITEBACK) ? r_lines[w_set][r_victim].data : '0;
  end
  // line storage: store hits, write-back completion and refill completion
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_lines[s][w] <= '0;
    end else if (w_idle_hit && bus.we) begin
      r_lines[w_set][w_hit_way].data  <= bus.wdata;
      r_lines[w_set][w_hit_way].dirty <= 1'b1;
    end else if (r_state == WRITEBACK && bus.mem_ack) begin
      r_lines[w_set][r_victim].dirty <= 1'b0;
    end else if (r_state == REFILL && bus.mem_ack) begin
      r_lines[w_set][r_victim] <= '{valid: 1'b1, dirty: 1'b0, tag: w_tag, data: bus.mem_rdata};
    end
  end
endmodule

// File: tb/tb_assoc_wb_cache.sv
// tb_assoc_wb_cache: directed and random accesses checked against a recency-queue cache model
module tb_assoc_wb_cache;
  localparam int WAYS = 2;
  typedef struct {
    logic [27:0] tag;
    logic [31:0] data;
    logic        dirty;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  ent_t q [4][$];
  logic [31:0] mem_m [logic [31:0]];
  always #5 clk = ~clk;
  assoc_wb_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  assoc_wb_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(4), .WAYS(WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tg, obs, want);
    end
  endtask
  task automatic serve(input logic w, input logic [31:0] a, input logic [31:0] d, input int n);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      chk("mem_req", bus.mem_req, 1);
      chk("mem_we", bus.mem_we, w);
      chk("mem_addr", bus.mem_addr, a);
      if (w) chk("mem_wdata", bus.mem_wdata, d);
      chk("wait_ready", bus.ready, 0);
      if (k == n) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = w ? $urandom : d;
      end
      @(posedge clk);
      #1;
    end
    bus.mem_ack = 1'b0;
  endtask
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input int n);
    logic [1:0]  sv;
    logic [27:0] t;
    logic [31:0] ra, rd;
    int          idx;
    ent_t        e;
    sv = a[3:2];
    t  = a[31:4];
    ra = {a[31:2], 2'b00};
    idx = -1;
    foreach (q[sv][i]) if (q[sv][i].tag == t) idx = i;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    if (idx >= 0) begin
      e = q[sv][idx];
      q[sv].delete(idx);
    end else begin
      @(negedge clk);
      chk("miss_ready", bus.ready, 0);
      chk("miss_hit", bus.hit, 0);
      @(posedge clk);
      #1;
      if (q[sv].size() == WAYS) begin
        e = q[sv].pop_back();
        if (e.dirty) begin
          serve(1'b1, {e.tag, sv, 2'b00}, e.data, n);
          mem_m[{e.tag, sv, 2'b00}] = e.data;
        end
      end
      rd = mem_m.exists(ra) ? mem_m[ra] : $urandom;
      mem_m[ra] = rd;
      serve(1'b0, ra, rd, n);
      e.tag = t; e.data = rd; e.dirty = 1'b0;
    end
    @(negedge clk);
    chk("ready", bus.ready, 1);
    chk("hit", bus.hit, 1);
    chk("rdata", bus.rdata, w ? 32'h0 : e.data);
    chk("mem_req_idle", bus.mem_req, 0);
    if (w) begin e.data = d; e.dirty = 1'b1; end
    q[sv].push_front(e);
    @(posedge clk);
    #1;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    foreach (q[i]) q[i].delete();
  endtask
  initial begin
    bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    do_reset();
    @(negedge clk);
    chk("rst_ready", bus.ready, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    mem_m[32'h40] = 32'hDEADBEEF;
    access(1'b0, 32'h40, 0, 0);
    access(1'b1, 32'h40, 32'h12345678, 0);
    access(1'b0, 32'h40, 0, 0);
    do_reset();
    access(1'b0, 32'h00, 0, 1);
    access(1'b0, 32'h20, 0, 0);
    access(1'b0, 32'h00, 0, 0);
    access(1'b0, 32'h40, 0, 2);
    access(1'b1, 32'h20, 32'hAAAA5555, 0);
    access(1'b0, 32'h40, 0, 0);
    access(1'b0, 32'h00, 0, 5);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_req", bus.mem_req, 0);
    @(posedge clk); #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_req2", bus.mem_req, 0);
    chk("stray_ack_ready", bus.ready, 0);
    @(posedge clk); #1;
    access(1'b1, 32'h00, 32'h0BADF00D, 0);
    access(1'b0, 32'h40, 0, 0);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h80;
    @(negedge clk);
    chk("rstwb_miss", bus.hit, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstwb_req", bus.mem_req, 1);
    chk("rstwb_we", bus.mem_we, 1);
    chk("rstwb_addr", bus.mem_addr, 32'h00);
    chk("rstwb_data", bus.mem_wdata, 32'h0BADF00D);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.req = 1'b0;
    @(negedge clk);
    chk("rstwb_req_drop", bus.mem_req, 0);
    chk("rstwb_we_drop", bus.mem_we, 0);
    chk("rstwb_ready", bus.ready, 0);
    foreach (q[i]) q[i].delete();
    @(posedge clk); #1;
    access(1'b0, 32'h40, 0, 0);
    access(1'b0, 32'h00, 0, 1);
    for (int i = 0; i < 150; i++)
      access(1'($urandom_range(0, 1)),
             (32'($urandom_range(0, 5)) << 4) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3)),
             $urandom, $urandom_range(0, 3));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
